// File: rtl/fir_filter.sv
// Fully parallel, pipelined, fixed-coefficient FIR filter.
// Optional symmetric / anti-symmetric folding shares one multiplier between mirrored taps.
module fir_filter #(
    parameter int INPUT_WIDTH        = 16,
    parameter int COEFF_WIDTH        = 16,
    parameter int OUTPUT_WIDTH       = 33,
    parameter int OUTPUT_WIDTH_FULL  = 33,
    parameter int SYMMETRY           = 1,
    parameter int NUM_TAPS           = 40,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{
        -16'sd283,  -16'sd858,  -16'sd1120, -16'sd1010, -16'sd640,
        -16'sd90,    16'sd450,   16'sd780,   16'sd720,   16'sd230,
        -16'sd520,  -16'sd1220, -16'sd1560, -16'sd1290, -16'sd210,
         16'sd1500,  16'sd1640,  16'sd3840,  16'sd4080,  16'sd26313,
         16'sd26313, 16'sd4080,  16'sd3840,  16'sd1640,  16'sd1500,
        -16'sd210,  -16'sd1290, -16'sd1560, -16'sd1220, -16'sd520,
         16'sd230,   16'sd720,   16'sd780,   16'sd450,  -16'sd90,
        -16'sd640,  -16'sd1010, -16'sd1120, -16'sd858,  -16'sd283
    },
    parameter int PIPELINE_MUL       = 1,
    parameter int PIPELINE_PREADD    = 1,
    parameter int PIPELINE_ADD_RATIO = 1,
    parameter int OUTPUT_REG         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic                           valid_out,
    output logic signed [OUTPUT_WIDTH-1:0] dout
);

    localparam int NUM_PAIRS  = NUM_TAPS / 2;
    localparam int NUM_PROD   = (SYMMETRY == 0) ? NUM_TAPS :
                                (SYMMETRY == 1) ? (NUM_TAPS + 1) / 2 : NUM_TAPS / 2;
    localparam int OPER_WIDTH = INPUT_WIDTH + ((SYMMETRY != 0) ? 1 : 0);
    localparam int PROD_WIDTH = OPER_WIDTH + COEFF_WIDTH;
    localparam int ACC_WIDTH  = OUTPUT_WIDTH_FULL;
    localparam int PRE_REG    = (SYMMETRY != 0 && PIPELINE_PREADD != 0) ? 1 : 0;
    localparam int MUL_REG    = (PIPELINE_MUL != 0) ? 1 : 0;
    localparam int TREE_DEPTH = $clog2(NUM_PROD);
    localparam int TREE_REGS  = (PIPELINE_ADD_RATIO > 0) ? TREE_DEPTH / PIPELINE_ADD_RATIO : 0;
    localparam int DATA_LAT   = 1 + PRE_REG + MUL_REG + TREE_REGS;

    // ------------------------------------------------------------------
    // Delay line: advances only on accepted samples.
    // ------------------------------------------------------------------
    logic signed [INPUT_WIDTH-1:0] taps [NUM_TAPS];

    // NOTE: the delay line is explicitly reset (not left as uninitialised storage)
    // so that a reset leaves no residue of earlier samples in later results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
        end else if (valid_in) begin
            // NOTE: non-blocking assignments make every tap shift from its pre-edge value.
            taps[0] <= din;
            for (int k = 1; k < NUM_TAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Pre-adders (folding) or straight pass of the taps.
    // ------------------------------------------------------------------
    logic signed [OPER_WIDTH-1:0] oper_c [NUM_PROD];
    logic signed [OPER_WIDTH-1:0] oper   [NUM_PROD];

    generate
        for (genvar m = 0; m < NUM_PROD; m++) begin : g_oper
            if (SYMMETRY == 0) begin : g_direct
                assign oper_c[m] = taps[m];
            end else if (m < NUM_PAIRS) begin : g_fold
                if (SYMMETRY == 1) begin : g_sym
                    assign oper_c[m] = OPER_WIDTH'(taps[m]) + OPER_WIDTH'(taps[NUM_TAPS-1-m]);
                end else begin : g_anti
                    assign oper_c[m] = OPER_WIDTH'(taps[m]) - OPER_WIDTH'(taps[NUM_TAPS-1-m]);
                end
            end else begin : g_middle
                // Odd-length symmetric filter: the centre tap has no mirror partner.
                assign oper_c[m] = OPER_WIDTH'(taps[m]);
            end
        end

        if (PRE_REG != 0) begin : g_pre_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int m = 0; m < NUM_PROD; m++) oper[m] <= '0;
                end else begin
                    for (int m = 0; m < NUM_PROD; m++) oper[m] <= oper_c[m];
                end
            end
        end else begin : g_pre_comb
            assign oper = oper_c;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multipliers: exact product, then sign-extended (or wrapped) to the accumulator width.
    // ------------------------------------------------------------------
    logic signed [PROD_WIDTH-1:0] full_c [NUM_PROD];
    logic signed [ACC_WIDTH-1:0]  prod_c [NUM_PROD];
    logic signed [ACC_WIDTH-1:0]  prod   [NUM_PROD];

    generate
        for (genvar m = 0; m < NUM_PROD; m++) begin : g_mul
            assign full_c[m] = PROD_WIDTH'(oper[m]) * PROD_WIDTH'(COEFFS[m]);
            assign prod_c[m] = ACC_WIDTH'(full_c[m]);
        end

        if (MUL_REG != 0) begin : g_mul_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int m = 0; m < NUM_PROD; m++) prod[m] <= '0;
                end else begin
                    for (int m = 0; m < NUM_PROD; m++) prod[m] <= prod_c[m];
                end
            end
        end else begin : g_mul_comb
            assign prod = prod_c;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Binary adder tree. Level l holds ceil(NUM_PROD / 2^l) partial sums; an unpaired
    // operand passes through the level (and its register, if any) to keep alignment.
    // ------------------------------------------------------------------
    generate
        for (genvar l = 0; l <= TREE_DEPTH; l++) begin : g_lvl
            localparam int CNT = (NUM_PROD + (1 << l) - 1) >> l;
            logic signed [ACC_WIDTH-1:0] val [CNT];

            if (l == 0) begin : g_leaf
                assign val = prod;
            end else begin : g_node
                localparam int PREV_CNT = (NUM_PROD + (1 << (l - 1)) - 1) >> (l - 1);
                localparam int RATIO    = (PIPELINE_ADD_RATIO > 0) ? PIPELINE_ADD_RATIO : 1;
                localparam bit LVL_REG  = (PIPELINE_ADD_RATIO > 0) && ((l % RATIO) == 0);
                logic signed [ACC_WIDTH-1:0] sum_c [CNT];

                for (genvar j = 0; j < CNT; j++) begin : g_sum
                    if (2 * j + 1 < PREV_CNT) begin : g_pair
                        assign sum_c[j] = g_lvl[l-1].val[2*j] + g_lvl[l-1].val[2*j+1];
                    end else begin : g_pass
                        assign sum_c[j] = g_lvl[l-1].val[2*j];
                    end
                end

                if (LVL_REG) begin : g_reg
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            for (int j = 0; j < CNT; j++) val[j] <= '0;
                        end else begin
                            for (int j = 0; j < CNT; j++) val[j] <= sum_c[j];
                        end
                    end
                end else begin : g_comb
                    assign val = sum_c;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Valid tracking and output stage.
    // ------------------------------------------------------------------
    logic [DATA_LAT-1:0]            valid_pipe;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [OUTPUT_WIDTH-1:0] dout_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= valid_in;
            for (int k = 1; k < DATA_LAT; k++) valid_pipe[k] <= valid_pipe[k-1];
        end
    end

    assign acc = g_lvl[TREE_DEPTH].val[0];
    // MSB-aligned truncation: keep the top OUTPUT_WIDTH bits, no rounding or saturation.
    assign dout_c = OUTPUT_WIDTH'(acc >>> (OUTPUT_WIDTH_FULL - OUTPUT_WIDTH));

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_out <= 1'b0;
                    dout      <= '0;
                end else begin
                    valid_out <= valid_pipe[DATA_LAT-1];
                    dout      <= dout_c;
                end
            end
        end else begin : g_out_comb
            assign valid_out = valid_pipe[DATA_LAT-1];
            assign dout      = dout_c;
        end
    endgenerate

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: default build plus three small parameter variants,
// all driven by one stimulus stream and checked against a direct-form reference model.
module tb_fir_filter;

    localparam int NCFG = 4;

    localparam logic signed [15:0] C40 [40] = '{
        -16'sd283,  -16'sd858,  -16'sd1120, -16'sd1010, -16'sd640,
        -16'sd90,    16'sd450,   16'sd780,   16'sd720,   16'sd230,
        -16'sd520,  -16'sd1220, -16'sd1560, -16'sd1290, -16'sd210,
         16'sd1500,  16'sd1640,  16'sd3840,  16'sd4080,  16'sd26313,
         16'sd26313, 16'sd4080,  16'sd3840,  16'sd1640,  16'sd1500,
        -16'sd210,  -16'sd1290, -16'sd1560, -16'sd1220, -16'sd520,
         16'sd230,   16'sd720,   16'sd780,   16'sd450,  -16'sd90,
        -16'sd640,  -16'sd1010, -16'sd1120, -16'sd858,  -16'sd283
    };
    localparam logic signed [15:0] CA [7] = '{16'sd3, -16'sd7, 16'sd12, 16'sd25, -16'sd4, 16'sd9, -16'sd15};
    localparam logic signed [15:0] CB [7] = '{16'sd5, -16'sd11, 16'sd20, 16'sd37, 16'sd20, -16'sd11, 16'sd5};
    localparam logic signed [15:0] CC [7] = '{16'sd6, -16'sd13, 16'sd21, 16'sd0, -16'sd21, 16'sd13, -16'sd6};

    localparam int NTAPS [NCFG] = '{40, 7, 7, 7};
    localparam int OWF   [NCFG] = '{33, 23, 23, 23};
    localparam int OW    [NCFG] = '{33, 16, 23, 16};

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic signed [15:0]  din;

    logic                vo0, vo1, vo2, vo3;
    logic signed [32:0]  do0;
    logic signed [15:0]  do1;
    logic signed [22:0]  do2;
    logic signed [15:0]  do3;

    logic [NCFG-1:0]     vo;
    longint              dv [NCFG];

    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     hist [40];
    int     coef [NCFG][40];
    int     lat_k [NCFG];
    exp_t   sb [NCFG][$];
    longint rec [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_filter u_dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo0), .dout(do0)
    );

    fir_filter #(
        .SYMMETRY(0), .NUM_TAPS(7), .COEFFS(CA), .OUTPUT_WIDTH(16), .OUTPUT_WIDTH_FULL(23),
        .PIPELINE_ADD_RATIO(2), .OUTPUT_REG(0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo1), .dout(do1)
    );

    fir_filter #(
        .SYMMETRY(1), .NUM_TAPS(7), .COEFFS(CB), .OUTPUT_WIDTH(23), .OUTPUT_WIDTH_FULL(23),
        .PIPELINE_ADD_RATIO(0), .OUTPUT_REG(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo2), .dout(do2)
    );

    fir_filter #(
        .SYMMETRY(2), .NUM_TAPS(7), .COEFFS(CC), .OUTPUT_WIDTH(16), .OUTPUT_WIDTH_FULL(23),
        .PIPELINE_MUL(0), .PIPELINE_ADD_RATIO(0), .OUTPUT_REG(0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .valid_out(vo3), .dout(do3)
    );

    always_comb begin
        vo    = {vo3, vo2, vo1, vo0};
        dv[0] = longint'(do0);
        dv[1] = longint'(do1);
        dv[2] = longint'(do2);
        dv[3] = longint'(do3);
    end

    // Latency straight from the filter's defining formula.
    function automatic int lat(int sym, int n, int pre, int mul, int ratio, int oreg);
        int m;
        int d;
        m = (sym == 0) ? n : (sym == 1) ? (n + 1) / 2 : n / 2;
        d = $clog2(m);
        return 1 + ((sym != 0) ? pre : 0) + mul + ((ratio == 0) ? 0 : d / ratio) + oreg;
    endfunction

    function automatic longint trunc(longint y, int full_w, int out_w);
        longint t;
        t = y <<< (64 - full_w);
        t = t >>> (64 - out_w);
        return t;
    endfunction

    function automatic longint model(int k);
        longint acc;
        acc = 0;
        for (int i = 0; i < NTAPS[k]; i++) acc += longint'(coef[k][i]) * longint'(hist[i]);
        return trunc(acc, OWF[k], OW[k]);
    endfunction

    // Step response of the default filter: -32768 times the running coefficient sum.
    function automatic longint step_exp(int i);
        longint s;
        s = 0;
        for (int k = 0; k <= ((i < 39) ? i : 39); k++) s += longint'(C40[k]);
        return -64'sd32768 * s;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic exp_valid;
        for (int k = 0; k < NCFG; k++) begin
            exp_valid = (sb[k].size() != 0) && (sb[k][0].due == cyc);
            check($sformatf("cfg%0d_valid_cyc%0d", k, cyc), longint'(vo[k]), longint'(exp_valid));
            if (exp_valid) begin
                e = sb[k].pop_front();
                if (vo[k]) check($sformatf("cfg%0d_dout_cyc%0d", k, cyc), dv[k], e.val);
            end
        end
        if (vo[0]) rec.push_back(dv[0]);
    endtask

    // Drive one cycle; entered and left just after a rising edge.
    task automatic step(input logic v, input logic signed [15:0] d);
        exp_t e;
        valid_in = v;
        din      = d;
        if (v && !rst) begin
            for (int i = 39; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(d);
            for (int k = 0; k < NCFG; k++) begin
                e.val = model(k);
                e.due = cyc + lat_k[k];
                sb[k].push_back(e);
            end
        end
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 40; i++) begin
            hist[i]    = 0;
            coef[0][i] = int'(C40[i]);
            coef[1][i] = 0;
            coef[2][i] = 0;
            coef[3][i] = 0;
            if (i < 7) begin
                coef[1][i] = int'(CA[i]);
                coef[2][i] = int'(CB[i]);
                coef[3][i] = int'(CC[i]);
            end
        end
        lat_k[0] = lat(1, 40, 1, 1, 1, 1);
        lat_k[1] = lat(0, 7, 1, 1, 2, 0);
        lat_k[2] = lat(1, 7, 1, 1, 0, 1);
        lat_k[3] = lat(2, 7, 1, 0, 0, 0);

        rst      = 1'b1;
        valid_in = 1'b0;
        din      = '0;
        @(posedge clk);
        #1;

        // Reset held: outputs quiet and zero.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 16'($urandom()));
            for (int k = 0; k < NCFG; k++) check($sformatf("rst_dout_cfg%0d", k), dv[k], 0);
        end
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 16'($urandom()));
            if (c % 10 == 0) check("idle_dout_cfg0", dv[0], 0);
        end

        // Impulse.
        rec.delete();
        step(1'b1, -16'sd32768);
        for (int i = 0; i < 47; i++) step(1'b1, 16'sd0);
        idle(12);
        check("impulse_count", rec.size(), 48);
        if (rec.size() >= 48) begin
            check("impulse_k0", rec[0], 64'sd9273344);
            check("impulse_k1", rec[1], 64'sd28114944);
            check("impulse_k19", rec[19], -64'sd862224384);
            check("impulse_k20", rec[20], -64'sd862224384);
            check("impulse_k39", rec[39], 64'sd9273344);
            check("impulse_k40", rec[40], 0);
        end

        // Gap-free step.
        rec.delete();
        for (int i = 0; i < 140; i++) step(1'b1, -16'sd32768);
        idle(12);
        check("step_count", rec.size(), 140);
        for (int i = 0; i < rec.size() && i < 140; i++) check($sformatf("step_%0d", i), rec[i], step_exp(i));
        if (rec.size() == 140) check("step_settled", rec[139], -64'sd2015363072);

        // Step with idle gaps (din scrambled while idle).
        for (int i = 0; i < 40; i++) step(1'b1, 16'sd0);
        idle(12);
        rec.delete();
        for (int i = 0; i < 140; i++) begin
            step(1'b1, -16'sd32768);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(12);
        check("gap_step_count", rec.size(), 140);
        for (int i = 0; i < rec.size() && i < 140; i++) check($sformatf("gap_step_%0d", i), rec[i], step_exp(i));

        // Reset asserted in the middle of a step.
        for (int i = 0; i < 20; i++) step(1'b1, -16'sd32768);
        valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("midrst_dout_cfg%0d", k), dv[k], 0);
            check($sformatf("midrst_valid_cfg%0d", k), longint'(vo[k]), 0);
            sb[k].delete();
        end
        for (int i = 0; i < 40; i++) hist[i] = 0;
        rec.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 16'sd0);
        rst = 1'b0;
        step(1'b1, -16'sd32768);
        for (int i = 0; i < 45; i++) step(1'b1, 16'sd0);
        idle(12);
        check("post_rst_impulse_count", rec.size(), 46);
        if (rec.size() >= 46) begin
            check("post_rst_k0", rec[0], 64'sd9273344);
            check("post_rst_k1", rec[1], 64'sd28114944);
            check("post_rst_k19", rec[19], -64'sd862224384);
            check("post_rst_k40", rec[40], 0);
        end

        // Random full-range samples with random gaps (exercises truncation in the variants).
        for (int i = 0; i < 80; i++) step($urandom_range(0, 3) != 0, 16'($urandom()));
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 16'sh7fff : -16'sd32768);
        idle(15);
        for (int k = 0; k < NCFG; k++) check($sformatf("drained_cfg%0d", k), sb[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
